// File: rtl/wb_interconnect_sharedbus_if.sv
// Wishbone B4 pipelined bus bundle.
// master drives the request side, slave drives the response side.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic        ack;
  logic        err;
  logic        stall;
  logic [31:0] dat_s;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  ack, err, stall, dat_s
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output ack, err, stall, dat_s
  );
endinterface

// File: rtl/wb_interconnect_sharedbus.sv
// Shared-bus pipelined Wishbone B4 interconnect, numm masters to nums slaves.
// Define WB_INTERCONNECT_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module wb_interconnect_sharedbus #(
  parameter int numm = 2,
  parameter int nums = 1,
  parameter logic [31:0] base_addr [nums] = '{default: 32'h0},
  parameter logic [31:0] size [nums] = '{default: 32'h10000}
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  wbm [numm],
  wb_if.master wbs [nums]
);
  logic [numm-1:0] m_cyc, m_stb, m_we;
  logic [31:0]     m_adr [numm];
  logic [3:0]      m_sel [numm];
  logic [31:0]     m_dat [numm];
  logic [numm-1:0] m_ack, m_err, m_stall;
  logic [31:0]     m_rdat [numm];

  logic [nums-1:0] s_ack, s_err, s_stall;
  logic [31:0]     s_rdat [nums];
  logic [nums-1:0] hit, ssel;

  logic [numm-1:0] grant_q, grant_d, gnt, pick;
  logic            busy_q, busy_d, keep;
  logic            err_q, err_d;
  logic [numm-1:0] err_gnt_q, err_gnt_d;

  logic            b_cyc, b_stb, b_we;
  logic [31:0]     b_adr, b_dat;
  logic [3:0]      b_sel;

  logic            r_ack, r_err, r_stall;
  logic [31:0]     r_dat;

`ifdef WB_INTERCONNECT_ROUND_ROBIN_EN
  logic [3:0] rr_q, rr_d;
  int         pick_idx;
`endif

  for (genvar i = 0; i < numm; i++) begin : g_m
    assign m_cyc[i]     = wbm[i].cyc;
    assign m_stb[i]     = wbm[i].stb;
    assign m_we[i]      = wbm[i].we;
    assign m_adr[i]     = wbm[i].adr;
    assign m_sel[i]     = wbm[i].sel;
    assign m_dat[i]     = wbm[i].dat_m;
    assign wbm[i].ack   = m_ack[i];
    assign wbm[i].err   = m_err[i];
    assign wbm[i].stall = m_stall[i];
    assign wbm[i].dat_s = m_rdat[i];
  end

  for (genvar j = 0; j < nums; j++) begin : g_s
    assign wbs[j].cyc   = ssel[j] & b_cyc;
    assign wbs[j].stb   = ssel[j] & b_cyc & b_stb;
    assign wbs[j].we    = b_we;
    assign wbs[j].adr   = b_adr;
    assign wbs[j].sel   = b_sel;
    assign wbs[j].dat_m = b_dat;
    assign s_ack[j]     = wbs[j].ack;
    assign s_err[j]     = wbs[j].err;
    assign s_stall[j]   = wbs[j].stall;
    assign s_rdat[j]    = wbs[j].dat_s;
  end

  // arbitration: hold the owner while its cyc stays up, else pick a new winner
  always_comb begin
    pick = '0;
`ifdef WB_INTERCONNECT_ROUND_ROBIN_EN
    pick_idx = 0;
    for (int off = numm - 1; off >= 0; off--) begin
      if (m_cyc[(int'(rr_q) + off) % numm]) begin
        pick     = numm'(1) << ((int'(rr_q) + off) % numm);
        pick_idx = (int'(rr_q) + off) % numm;
      end
    end
`else
    for (int i = numm - 1; i >= 0; i--) begin
      if (m_cyc[i]) pick = numm'(1) << i;
    end
`endif
    keep = busy_q && (|(grant_q & m_cyc));
    if (!rst_n)    gnt = '0;
    else if (keep) gnt = grant_q;
    else           gnt = pick;
    grant_d = gnt;
    busy_d  = |gnt;
`ifdef WB_INTERCONNECT_ROUND_ROBIN_EN
    rr_d = rr_q;
    if (rst_n && !keep && (|pick)) rr_d = 4'((pick_idx + 1) % numm);
`endif
  end

  // shared request bus driven by the granted master
  always_comb begin
    b_cyc = 1'b0;
    b_stb = 1'b0;
    b_we  = 1'b0;
    b_adr = '0;
    b_sel = '0;
    b_dat = '0;
    for (int i = 0; i < numm; i++) begin
      if (gnt[i]) begin
        b_cyc = m_cyc[i];
        b_stb = m_stb[i];
        b_we  = m_we[i];
        b_adr = m_adr[i];
        b_sel = m_sel[i];
        b_dat = m_dat[i];
      end
    end
  end

  // 33-bit window decode; the lowest matching slave wins overlaps
  always_comb begin
    hit  = '0;
    ssel = '0;
    for (int j = 0; j < nums; j++) begin
      hit[j] = ({1'b0, b_adr} >= {1'b0, base_addr[j]}) &&
               ({1'b0, b_adr} < ({1'b0, base_addr[j]} + {1'b0, size[j]}));
    end
    for (int j = nums - 1; j >= 0; j--) begin
      if (hit[j]) ssel = nums'(1) << j;
    end
    err_d     = b_cyc & b_stb & ~(|hit);
    err_gnt_d = gnt;
  end

  // response path from the selected slave back to the owner
  always_comb begin
    r_ack   = 1'b0;
    r_err   = 1'b0;
    r_stall = 1'b0;
    r_dat   = '0;
    for (int j = 0; j < nums; j++) begin
      if (ssel[j]) begin
        r_ack   = s_ack[j];
        r_err   = s_err[j];
        r_stall = s_stall[j];
        r_dat   = s_rdat[j];
      end
    end
    for (int i = 0; i < numm; i++) begin
      m_ack[i]   = gnt[i] & r_ack;
      m_err[i]   = gnt[i] & (r_err | (err_q & err_gnt_q[i]));
      m_stall[i] = gnt[i] ? r_stall : 1'b1;
      m_rdat[i]  = gnt[i] ? r_dat : 32'h0;
    end
  end

  // ownership and pending decode-error state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_gnt_q <= '0;
`ifdef WB_INTERCONNECT_ROUND_ROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_gnt_q <= err_gnt_d;
`ifdef WB_INTERCONNECT_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_interconnect_sharedbus.sv
// Directed bench for wb_interconnect_sharedbus: 2 masters, one RAM slave.
// Responses are scored against a queue of expectations built at issue time.
module tb_wb_interconnect_sharedbus;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_if m_if [2] ();
  wb_if s_if [1] ();

  wb_interconnect_sharedbus #(
    .numm(2),
    .nums(1),
    .base_addr('{32'h0}),
    .size('{32'h10000})
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wbm(m_if),
    .wbs(s_if)
  );

  logic        mc [2];
  logic        ms [2];
  logic        mw [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic        mack [2];
  logic        merr [2];
  logic        mstall [2];
  logic [31:0] mdat [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign m_if[g].cyc   = mc[g];
    assign m_if[g].stb   = ms[g];
    assign m_if[g].we    = mw[g];
    assign m_if[g].adr   = ma[g];
    assign m_if[g].sel   = 4'hF;
    assign m_if[g].dat_m = md[g];
    assign mack[g]       = m_if[g].ack;
    assign merr[g]       = m_if[g].err;
    assign mstall[g]     = m_if[g].stall;
    assign mdat[g]       = m_if[g].dat_s;
  end

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic        r_ack;
  logic [31:0] r_dat;
  logic [31:0] ram [0:16383];

  assign s_cyc           = s_if[0].cyc;
  assign s_stb           = s_if[0].stb;
  assign s_we            = s_if[0].we;
  assign s_adr           = s_if[0].adr;
  assign s_wdat          = s_if[0].dat_m;
  assign s_if[0].ack     = r_ack;
  assign s_if[0].err     = 1'b0;
  assign s_if[0].stall   = 1'b0;
  assign s_if[0].dat_s   = r_dat;

  // RAM slave: never stalls, acks one cycle after each accepted beat
  always @(posedge clk) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= s_cyc && s_stb;
      if (s_cyc && s_stb) begin
        if (s_we) ram[s_adr[15:2]] <= s_wdat;
        r_dat <= ram[s_adr[15:2]];
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [logic [31:0]];

  // one Wishbone beat on master m; keep leaves cyc asserted afterwards
  task automatic beat(input int m, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit keep);
    exp_t e;
    bit   acc;
    bit   got;
    int   wt;
    bit   hit;
    hit   = (a < 32'h10000);
    e.err = !hit;
    e.rd  = !we && hit;
    e.dat = (e.rd && model.exists(a)) ? model[a] : 32'h0;
    mc[m] = 1'b1;
    ms[m] = 1'b1;
    mw[m] = we;
    ma[m] = a;
    md[m] = d;
    acc   = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      if (!mstall[m]) begin
        acc = 1'b1;
        if (!hit) chk("nohit_slave_stb", {31'b0, s_stb}, 32'h0);
        if (we && hit) model[a] = d;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    chk("accept", {31'b0, acc}, 32'h1);
    ms[m] = 1'b0;
    got   = 1'b0;
    wt    = 0;
    if (acc) begin
      for (int n = 0; n < 20 && !got; n++) begin
        #1;
        if (mack[m] || merr[m]) got = 1'b1;
        else begin
          wt++;
          @(negedge clk);
        end
      end
      chk("response", {31'b0, got}, 32'h1);
      if (got) begin
        e = sb.pop_front();
        chk("latency", wt, 32'h0);
        chk("err", {31'b0, merr[m]}, {31'b0, e.err});
        chk("ack", {31'b0, mack[m]}, {31'b0, !e.err});
        if (e.rd) chk("rdata", mdat[m], e.dat);
      end
    end
    if (!keep) begin
      mc[m] = 1'b0;
      @(negedge clk);
    end
  endtask

  // bus protocol watch on every port, sampled mid-low-phase
  always @(negedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("m_ack_err", {31'b0, mack[i] & merr[i]}, 32'h0);
      chk("m_ack_cyc", {31'b0, mack[i] & !mc[i]}, 32'h0);
      chk("m_stb_cyc", {31'b0, ms[i] & !mc[i]}, 32'h0);
    end
    chk("s_stb_cyc", {31'b0, s_stb & !s_cyc}, 32'h0);
    chk("s_ack_cyc", {31'b0, r_ack & !s_cyc & s_stb}, 32'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 1'b0;
      ms[i] = 1'b0;
      mw[i] = 1'b0;
      ma[i] = '0;
      md[i] = '0;
    end
    repeat (2) @(negedge clk);

    // requests during reset are ignored
    mc[0] = 1'b1;
    mc[1] = 1'b1;
    ms[0] = 1'b1;
    #1;
    chk("rst_stall0", {31'b0, mstall[0]}, 32'h1);
    chk("rst_stall1", {31'b0, mstall[1]}, 32'h1);
    chk("rst_ack0", {31'b0, mack[0]}, 32'h0);
    chk("rst_err0", {31'b0, merr[0]}, 32'h0);
    chk("rst_scyc", {31'b0, s_cyc}, 32'h0);
    chk("rst_sstb", {31'b0, s_stb}, 32'h0);
    mc[0] = 1'b0;
    mc[1] = 1'b0;
    ms[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // master1 write then read back
    beat(1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
    beat(1, 1'b0, 32'h100, 32'h0, 1'b0);

    // master0 patterns incl. last word of the window
    beat(0, 1'b1, 32'h0, 32'h12345678, 1'b0);
    beat(0, 1'b1, 32'hFFFC, 32'hA5A55A5A, 1'b0);
    beat(0, 1'b0, 32'hFFFC, 32'h0, 1'b0);
    beat(0, 1'b0, 32'h0, 32'h0, 1'b0);

    // out-of-window accesses
    beat(0, 1'b0, 32'h10000, 32'h0, 1'b0);
    beat(1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);

    // two beats within one held cycle
    beat(0, 1'b1, 32'h200, 32'h0BADF00D, 1'b1);
    beat(0, 1'b0, 32'h200, 32'h0, 1'b0);

    // simultaneous request: master0 wins, master1 waits
    ma[0] = 32'h40;
    ma[1] = 32'h80;
    mc[0] = 1'b1;
    mc[1] = 1'b1;
    #1;
    chk("arb_stall0", {31'b0, mstall[0]}, 32'h0);
    chk("arb_stall1", {31'b0, mstall[1]}, 32'h1);
    chk("arb_dat1", mdat[1], 32'h0);
    chk("arb_sadr", s_adr, 32'h40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("arb_hold1", {31'b0, mstall[1]}, 32'h1);
    end
    @(negedge clk);
    mc[0] = 1'b0;
    #1;
    chk("handoff_stall1", {31'b0, mstall[1]}, 32'h0);
    chk("handoff_stall0", {31'b0, mstall[0]}, 32'h1);
    chk("handoff_sadr", s_adr, 32'h80);
    chk("handoff_scyc", {31'b0, s_cyc}, 32'h1);
    beat(1, 1'b0, 32'h100, 32'h0, 1'b0);

    // reset pulse mid-burst
    beat(0, 1'b1, 32'h300, 32'hCAFEF00D, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", {31'b0, mstall[0]}, 32'h1);
    chk("rstmid_ack", {31'b0, mack[0]}, 32'h0);
    chk("rstmid_scyc", {31'b0, s_cyc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mc[0] = 1'b0;
    #1;
    chk("rstpost_stall", {31'b0, mstall[0]}, 32'h1);
    chk("rstpost_scyc", {31'b0, s_cyc}, 32'h0);
    @(negedge clk);
    beat(0, 1'b0, 32'h300, 32'h0, 1'b0);

    chk("sb_drained", sb.size(), 32'h0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
